// File: rtl/peri_reg_split.sv
// peri_reg_split
//   Register-bus splitter between the peripheral register port and NCH
//   sub-blocks. The select field reg_addr[AW-1 -: SELW] picks one channel.
//   Unmapped selects are answered locally with an error response. The optional
//   timeout turns a silent channel into an error response, so every access
//   completes.
//
//   Optional feature macro: PERI_SPLIT_TIMEOUT_EN
//     defined   : 16-bit wait counter; after TO_CYC WAIT cycles without ack the
//                 access completes with reg_rdata = ERR_DATA and bus_err.
//     undefined : WAIT holds until the selected channel acks.
//
// Ports
//   mclk, s_reset_n      clock, asynchronous active-low reset
//   reg_cs/wr/addr/      master request (held until reg_ack), direction,
//   wdata/be             byte address, write data, byte enables
//   reg_rdata            registered read data
//   reg_ack              one-cycle completion pulse
//   bus_err              one-cycle pulse coincident with an error reg_ack
//   err_cnt              saturating count of error completions
//   s_cs                 one-hot sub-block chip-select
//   s_wr/addr/wdata/be   request fields latched for the whole access
//   s_rdata              channel i at bits [32*i+31:32*i]
//   s_ack                per-channel ack
module peri_reg_split #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned AW       = 11,
  parameter int unsigned SELW     = 4,
  parameter int unsigned TO_CYC   = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                mclk,
  input  logic                s_reset_n,
  input  logic                reg_cs,
  input  logic                reg_wr,
  input  logic [AW-1:0]       reg_addr,
  input  logic [31:0]         reg_wdata,
  input  logic [3:0]          reg_be,
  output logic [31:0]         reg_rdata,
  output logic                reg_ack,
  output logic                bus_err,
  output logic [7:0]          err_cnt,
  output logic [NCH-1:0]      s_cs,
  output logic                s_wr,
  output logic [AW-SELW-1:0]  s_addr,
  output logic [31:0]         s_wdata,
  output logic [3:0]          s_be,
  input  logic [NCH*32-1:0]   s_rdata,
  input  logic [NCH-1:0]      s_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_in;
  logic            mapped;
  logic            ack_hit;
  logic [31:0]     ack_data;
  logic            latch_req;
  logic [NCH-1:0]  s_cs_d;
  logic            reg_ack_d;
  logic            bus_err_d;
  logic [31:0]     rdata_d;
  logic            to_hit;

  assign sel_in = reg_addr[AW-1 -: SELW];
  assign mapped = ({1'b0, sel_in} < NCH_L);

  // s_cs is one-hot on the latched select, so masking with it both ignores
  // stray acks and avoids indexing with a select wider than the channel count.
  assign ack_hit = |(s_ack & s_cs);

  always_comb begin
    ack_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (s_cs[i]) begin
        ack_data = ack_data | s_rdata[32*i +: 32];
      end
    end
  end

`ifdef PERI_SPLIT_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == 16'(TO_CYC - 1));

  always_ff @(posedge mclk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    s_cs_d    = s_cs;
    reg_ack_d = 1'b0;
    bus_err_d = 1'b0;
    rdata_d   = reg_rdata;
    latch_req = 1'b0;
`ifdef PERI_SPLIT_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reg_cs) begin
          latch_req = 1'b1;
          if (mapped) begin
            state_d = WAIT;
            s_cs_d  = NCH'(1) << sel_in;
`ifdef PERI_SPLIT_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            state_d   = RESP;
            reg_ack_d = 1'b1;
            bus_err_d = 1'b1;
            rdata_d   = '0;
          end
        end
      end
      WAIT: begin
        // Ack is tested first so an ack on the expiry cycle completes normally.
        if (ack_hit) begin
          state_d   = RESP;
          reg_ack_d = 1'b1;
          s_cs_d    = '0;
          rdata_d   = s_wr ? 32'h0 : ack_data;
        end else if (to_hit) begin
          state_d   = RESP;
          reg_ack_d = 1'b1;
          bus_err_d = 1'b1;
          s_cs_d    = '0;
          rdata_d   = ERR_DATA;
        end else begin
`ifdef PERI_SPLIT_TIMEOUT_EN
          to_cnt_d = to_cnt_q + 16'd1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_cs_d  = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      state_q   <= IDLE;
      s_cs      <= '0;
      reg_ack   <= 1'b0;
      bus_err   <= 1'b0;
      reg_rdata <= '0;
      err_cnt   <= '0;
      s_wr      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
    end else begin
      state_q   <= state_d;
      s_cs      <= s_cs_d;
      reg_ack   <= reg_ack_d;
      bus_err   <= bus_err_d;
      reg_rdata <= rdata_d;
      if (bus_err_d && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (latch_req) begin
        s_wr    <= reg_wr;
        s_addr  <= reg_addr[AW-SELW-1:0];
        s_wdata <= reg_wdata;
        s_be    <= reg_be;
      end
    end
  end

endmodule
